// File: rtl/lectura.sv
// RTC parallel-bus read sequencer: optional latch command, one read, 4-phase done.
// Define LECTURA_TIMEOUT_EN for the fin watchdog; "final" is reserved, hence finalizado.
module lectura #(
   parameter logic [7:0] CMD_CLK = 8'hF0,
   parameter logic [7:0] CMD_TMR = 8'hF2
`ifdef LECTURA_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 256
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [7:0] dir,
   input  logic       fin,
   input  logic [7:0] data_in,
   output logic [7:0] dir_out,
   output logic [7:0] data_out,
   output logic       escribe,
   output logic       lee,
   output logic       activa,
   output logic [7:0] dato_leido,
   output logic       finalizado,
   output logic       error
);

   typedef enum logic [2:0] {
      INICIO,
      LATCH,
      READ,
      FINALIZAR,
      ERROR
   } estado_t;

   estado_t estado, estado_n;

   logic       es_reloj, es_timer;
   logic       expira;
   logic [7:0] dir_n, dout_n, dato_n;
   logic       esc_n, lee_n, act_n, fin_n;

   assign es_reloj = (dir >= 8'h21) && (dir <= 8'h26);
   assign es_timer = (dir >= 8'h41) && (dir <= 8'h43);

   // Dropping iniciar wins over fin and over the watchdog.
   always_comb begin
      estado_n = estado;
      case (estado)
         INICIO: begin
            if (iniciar)
               estado_n = (es_reloj || es_timer) ? LATCH : READ;
         end
         LATCH: begin
            if (!iniciar)     estado_n = INICIO;
            else if (fin)     estado_n = READ;
            else if (expira)  estado_n = ERROR;
         end
         READ: begin
            if (!iniciar)     estado_n = INICIO;
            else if (fin)     estado_n = FINALIZAR;
            else if (expira)  estado_n = ERROR;
         end
         FINALIZAR, ERROR: begin
            if (!iniciar)     estado_n = INICIO;
         end
         default: estado_n = INICIO;
      endcase
   end

   // Outputs are decoded from the next state so they move with it.
   always_comb begin
      dir_n  = 8'h00;
      dout_n = 8'h00;
      dato_n = 8'h00;
      esc_n  = 1'b0;
      lee_n  = 1'b0;
      act_n  = 1'b0;
      fin_n  = 1'b0;
      case (estado_n)
         LATCH: begin
            esc_n  = 1'b1;
            act_n  = 1'b1;
            dir_n  = es_timer ? CMD_TMR : CMD_CLK;
            dout_n = es_timer ? CMD_TMR : CMD_CLK;
         end
         READ: begin
            lee_n = 1'b1;
            act_n = 1'b1;
            dir_n = dir;
         end
         FINALIZAR: begin
            fin_n  = 1'b1;
            dato_n = (estado == READ) ? data_in : dato_leido;
         end
         ERROR: begin
            fin_n = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado     <= INICIO;
         dir_out    <= 8'h00;
         data_out   <= 8'h00;
         escribe    <= 1'b0;
         lee        <= 1'b0;
         activa     <= 1'b0;
         dato_leido <= 8'h00;
         finalizado <= 1'b0;
      end else begin
         estado     <= estado_n;
         dir_out    <= dir_n;
         data_out   <= dout_n;
         escribe    <= esc_n;
         lee        <= lee_n;
         activa     <= act_n;
         dato_leido <= dato_n;
         finalizado <= fin_n;
      end
   end

`ifdef LECTURA_TIMEOUT_EN
   logic [15:0] cuenta;
   logic        espera;

   assign espera = (estado == LATCH) || (estado == READ);
   assign expira = (cuenta == 16'(TIMEOUT - 1));

   // Cleared on every entry to a waiting state, including LATCH -> READ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cuenta <= 16'h0000;
      else if ((estado_n == LATCH || estado_n == READ) && estado_n != estado)
         cuenta <= 16'h0000;
      else if (espera)
         cuenta <= cuenta + 16'h0001;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         error <= 1'b0;
      else
         error <= (estado_n == ERROR);
   end
`else
   assign expira = 1'b0;
   assign error  = 1'b0;
`endif

endmodule

// File: tb/tb_lectura.sv
// Bench for lectura: vector table of reads plus abort, async reset and watchdog.
module tb_lectura;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic [7:0] dir = 8'h00;
   logic       fin = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] dir_out, data_out, dato_leido;
   logic       escribe, lee, activa, finalizado, error;

   lectura #(
      .CMD_CLK(8'hF0),
      .CMD_TMR(8'hF2)
`ifdef LECTURA_TIMEOUT_EN
      ,
      .TIMEOUT(16)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .iniciar(iniciar),
      .dir(dir),
      .fin(fin),
      .data_in(data_in),
      .dir_out(dir_out),
      .data_out(data_out),
      .escribe(escribe),
      .lee(lee),
      .activa(activa),
      .dato_leido(dato_leido),
      .finalizado(finalizado),
      .error(error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] dir;
      logic [7:0] dato;
      logic       latch;
      logic [7:0] cmd;
   } vec_t;

   vec_t tabla[12];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   function automatic logic [31:0] bus();
      return {11'b0, error, finalizado, activa, lee, escribe, dir_out, data_out};
   endfunction

   function automatic logic [31:0] mk(input logic er, input logic fi,
                                      input logic ac, input logic le,
                                      input logic es, input logic [7:0] d,
                                      input logic [7:0] o);
      return {11'b0, er, fi, ac, le, es, d, o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic transaccion(input vec_t v, input int espera);
      iniciar = 1'b1;
      dir = v.dir;
      tick();
      if (v.latch) begin
         chk("latch", bus(), mk(0, 0, 1, 0, 1, v.cmd, v.cmd));
         repeat (espera) tick();
         chk("latch_hold", bus(), mk(0, 0, 1, 0, 1, v.cmd, v.cmd));
         fin = 1'b1;
         data_in = 8'h77;
         tick();
         fin = 1'b0;
      end
      chk("read", bus(), mk(0, 0, 1, 1, 0, v.dir, 8'h00));
      chk8("read_dato", dato_leido, 8'h00);
      repeat (espera) tick();
      chk("read_hold", bus(), mk(0, 0, 1, 1, 0, v.dir, 8'h00));
      fin = 1'b1;
      data_in = v.dato;
      exp_q.push_back(v.dato);
      tick();
      fin = 1'b0;
      data_in = ~v.dato;
      chk("final", bus(), mk(0, 1, 0, 0, 0, 8'h00, 8'h00));
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: got empty want entry");
      end else begin
         chk8("dato", dato_leido, exp_q.pop_front());
      end
      fin = 1'b1;
      tick();
      fin = 1'b0;
      chk("final_hold", bus(), mk(0, 1, 0, 0, 0, 8'h00, 8'h00));
      chk8("dato_hold", dato_leido, v.dato);
      iniciar = 1'b0;
      tick();
      chk("idle", bus(), 0);
      chk8("idle_dato", dato_leido, 8'h00);
   endtask

   initial begin
      bit ok;
      tabla[0]  = '{8'h05, 8'h3C, 1'b0, 8'h00};
      tabla[1]  = '{8'h22, 8'h59, 1'b1, 8'hF0};
      tabla[2]  = '{8'h42, 8'hA5, 1'b1, 8'hF2};
      tabla[3]  = '{8'h21, 8'h01, 1'b1, 8'hF0};
      tabla[4]  = '{8'h26, 8'hFE, 1'b1, 8'hF0};
      tabla[5]  = '{8'h20, 8'h80, 1'b0, 8'h00};
      tabla[6]  = '{8'h27, 8'h7F, 1'b0, 8'h00};
      tabla[7]  = '{8'h41, 8'h5A, 1'b1, 8'hF2};
      tabla[8]  = '{8'h43, 8'hC3, 1'b1, 8'hF2};
      tabla[9]  = '{8'h40, 8'h11, 1'b0, 8'h00};
      tabla[10] = '{8'h44, 8'h00, 1'b0, 8'h00};
      tabla[11] = '{8'hFF, 8'hFF, 1'b0, 8'h00};

      repeat (2) tick();
      chk("reset", bus(), 0);
      chk8("reset_dato", dato_leido, 8'h00);
      reset = 1'b1;
      tick();
      chk("post_reset", bus(), 0);

      for (int i = 0; i < 12; i++)
         transaccion(tabla[i], (i == 0) ? 3 : i % 4);

      // iniciar drops in READ on the same cycle as fin
      iniciar = 1'b1;
      dir = 8'h10;
      tick();
      chk("abort_read", bus(), mk(0, 0, 1, 1, 0, 8'h10, 8'h00));
      iniciar = 1'b0;
      fin = 1'b1;
      data_in = 8'hAA;
      tick();
      fin = 1'b0;
      chk("abort_idle", bus(), 0);
      chk8("abort_dato", dato_leido, 8'h00);
      tick();
      chk("abort_nofinal", bus(), 0);

      // abort while waiting in LATCH
      iniciar = 1'b1;
      dir = 8'h23;
      tick();
      chk("abort_latch", bus(), mk(0, 0, 1, 0, 1, 8'hF0, 8'hF0));
      iniciar = 1'b0;
      tick();
      chk("abort_latch_idle", bus(), 0);

      // asynchronous reset between edges
      iniciar = 1'b1;
      dir = 8'h22;
      tick();
      chk("rst_latch", bus(), mk(0, 0, 1, 0, 1, 8'hF0, 8'hF0));
      #2 reset = 1'b0;
      #1;
      chk("rst_async", bus(), 0);
      reset = 1'b1;
      tick();
      chk("rst_restart", bus(), mk(0, 0, 1, 0, 1, 8'hF0, 8'hF0));
      iniciar = 1'b0;
      tick();
      chk("rst_idle", bus(), 0);

      // no fin in READ
      iniciar = 1'b1;
      dir = 8'h10;
      data_in = 8'h99;
      tick();
`ifdef LECTURA_TIMEOUT_EN
      repeat (15) tick();
      chk("tmo_wait", bus(), mk(0, 0, 1, 1, 0, 8'h10, 8'h00));
      tick();
      chk("tmo_error", bus(), mk(1, 1, 0, 0, 0, 8'h00, 8'h00));
      chk8("tmo_dato", dato_leido, 8'h00);
      tick();
      chk("tmo_hold", bus(), mk(1, 1, 0, 0, 0, 8'h00, 8'h00));
`else
      ok = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (lee !== 1'b1 || error !== 1'b0) ok = 1'b0;
         tick();
      end
      chk("no_timeout", {31'b0, ok}, 1);
`endif
      iniciar = 1'b0;
      tick();
      chk("tmo_idle", bus(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
